// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer: paired cache lookup, miss refill, redirect handling
module fetch_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 delete_tagged,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_address,
  input  logic                 stop,
  input  logic [1:0]           hit,
  output logic                 cache_read,
  output logic [1:0][XLEN-1:0] cache_address,
  output logic                 refill_req,
  output logic [XLEN-1:0]      refill_address,
  input  logic                 refill_ack,
  output logic                 fetch_valid,
  output logic [15:0]          miss_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MISS  = 2'd1,
    RETRY = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus8;
  logic [XLEN-1:0] redirect_pc;
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;

  assign pc_plus4    = pc + XLEN'(4);
  assign pc_plus8    = pc + XLEN'(8);
  assign redirect_pc = redirect_address & ~XLEN'(3);

  assign cache_read       = (state == RUN);
  assign cache_address[0] = pc;
  assign cache_address[1] = pc_plus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      pc             <= RESET_PC;
      fetch_valid    <= 1'b0;
      refill_req     <= 1'b0;
      refill_address <= '0;
      miss_count     <= '0;
      pend_valid     <= 1'b0;
      pend_pc        <= '0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        RUN: begin
          // Redirect outranks miss, stop and flush; a miss still refills under stop.
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (hit != 2'b11) begin
            state          <= MISS;
            refill_req     <= 1'b1;
            refill_address <= hit[0] ? pc_plus4 : pc;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end else if (!stop && !delete_tagged) begin
            pc          <= pc_plus8;
            fetch_valid <= 1'b1;
          end
        end
        MISS: begin
          if (refill_ack) begin
            refill_req <= 1'b0;
            state      <= RETRY;
            pend_valid <= 1'b0;
            if (redirect_valid)  pc <= redirect_pc;
            else if (pend_valid) pc <= pend_pc;
          end else if (redirect_valid) begin
            pend_valid <= 1'b1;
            pend_pc    <= redirect_pc;
          end
        end
        RETRY: begin
          state <= RUN;
          if (redirect_valid) pc <= redirect_pc;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter XLEN, default 32: address width.
REQ-002 Parameter RESET_PC, default 0: fetch address after reset; bits [1:0] SHALL be 0.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 delete_tagged  in  1  flush; discard the pair fetched this cycle.
REQ-006 redirect_valid  in  1  one-cycle pulse requesting a new fetch PC.
REQ-007 redirect_address  in  XLEN  target PC; bits [1:0] are ignored.
REQ-008 stop  in  1  downstream backpressure; hold PC.
REQ-009 hit  in  2  per-slot instruction-cache hit for the current cache_address, same cycle.
REQ-010 cache_read  out  1  lookup request for cache_address[0..1].
REQ-011 cache_address  out  2xXLEN  [0]=pc, [1]=pc+4.
REQ-012 refill_req  out  1  miss refill request; level-held until acknowledged.
REQ-013 refill_address  out  XLEN  address of the missing word.
REQ-014 refill_ack  in  1  one-cycle pulse; refill complete.
REQ-015 fetch_valid  out  1  registered pulse; pair accepted, PC advanced by 8.
REQ-016 miss_count  out  16  saturating count of refills issued.

Function
REQ-017 The FSM SHALL have three states: RUN, MISS and RETRY; the reset state SHALL be RUN.
REQ-018 In RUN, cache_read SHALL be 1, and cache_address[0] and [1] SHALL be driven from the pc register, combinationally from state.
REQ-019 In RUN with hit==2'b11, !stop, !delete_tagged and !redirect_valid, pc SHALL be set to pc+8 modulo 2^XLEN and fetch_valid SHALL be 1 in the next cycle.
REQ-020 In RUN with hit!=2'b11 and no redirect, the FSM SHALL enter MISS, with refill_address set to pc if !hit[0], otherwise to pc+4.
REQ-021 A miss entering MISS SHALL increment miss_count by 1; miss_count SHALL saturate at 16'hFFFF.
REQ-022 In MISS, cache_read SHALL be 0, and refill_req and refill_address SHALL be held stable until refill_ack is sampled at 1.
REQ-023 refill_ack in MISS SHALL cause refill_req to fall in the next cycle and the FSM to enter RETRY.
REQ-024 RETRY SHALL last exactly one cycle with cache_read 0, then the FSM SHALL return to RUN and re-look up the same pc.
REQ-025 refill_ack outside MISS SHALL be ignored.
REQ-026 stop in RUN SHALL hold pc and force fetch_valid to 0 in the next cycle; a miss under stop SHALL still enter MISS.
REQ-027 redirect_valid in RUN or RETRY SHALL set pc to {redirect_address[XLEN-1:2],2'b00}, suppress fetch_valid, and enter or stay in RUN, taking priority over hit, stop and miss.
REQ-028 redirect_valid in MISS SHALL NOT drop refill_req; the target SHALL be stored as a pending redirect and applied to pc on the cycle refill_ack is sampled.
REQ-029 A later redirect in MISS SHALL overwrite the pending redirect.
REQ-030 delete_tagged SHALL force fetch_valid to 0 in the next cycle and hold pc unless redirect_valid is also 1.
REQ-031 delete_tagged SHALL NOT abort an outstanding refill.
REQ-032 Redirect and miss in the same RUN cycle SHALL take the redirect and issue no refill.
REQ-033 pc+4 and pc+8 SHALL wrap modulo 2^XLEN, e.g. pc=FFFF_FFF8 advances to 0000_0000.
REQ-034 fetch_valid SHALL never be 1 in two consecutive cycles unless hits were accepted in two consecutive RUN cycles.

Reset
REQ-035 While reset==0, regardless of clk: pc=RESET_PC, state=RUN, fetch_valid=0, refill_req=0, refill_address=0, miss_count=0, and the pending redirect is cleared.
REQ-036 Reset asserted during MISS SHALL drop refill_req immediately; no refill_ack is expected afterwards.
REQ-037 cache_read SHALL be 1 in the first cycle after reset releases.

Verification
REQ-038 Streaming: reset release with RESET_PC=0 and hit=11 for 3 cycles -> cache_address[0] is 0, 8, 10h; fetch_valid is 1 for 3 cycles; pc=18h.
REQ-039 Miss: pc=100h, hit=01 -> refill_req=1 with refill_address=104h and miss_count=1; refill_ack after 5 cycles -> RETRY for 1 cycle, then re-lookup at 100h.
REQ-040 Redirect in MISS: redirect 2003h during refill -> refill_req is held; on refill_ack, pc=2000h.
REQ-041 Stop and flush: hit=11 with stop=1 for 2 cycles -> pc is unchanged and fetch_valid=0; delete_tagged with hit=11 -> fetch_valid=0 and pc is unchanged.
REQ-042 Wrap: pc=FFFF_FFF8 with hit=11 -> cache_address[1]=FFFF_FFFC, then pc=0.
REQ-043 Async reset: reset=0 mid-MISS between clock edges -> refill_req=0 and miss_count=0 immediately.
